bin_div_4bits_seq: RTL and testbench
====================================

# bin_div_4bits_seq

Sequential restoring binary divider, the inverse of the team's shift-add multiplier. It accepts an unsigned dividend and divisor on a start pulse and runs one shift-subtract step per clock, MSB first. It then presents the quotient and remainder with a one-cycle done strobe. It sits beside the multiplier in the combinational/arithmetic projects as a shared multi-cycle arithmetic unit.

## Interface
- WIDTH, 4, operand width in bits; valid for WIDTH ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  dividend, unsigned; latched on accept.
- B  input  WIDTH  divisor, unsigned; latched on accept.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; results valid.
- Q  output  WIDTH  quotient; held until the next completion.
- R  output  WIDTH  remainder; held until the next completion.
- dbz  output  1  divide-by-zero flag; meaningful with done; see Configuration.

## Operation
- States:
  - IDLE: start=1 latches A→dividend shift register and B→divisor register, clears the working remainder, sets step counter = WIDTH, and moves to CALC.
  - CALC: performs one restoring step per cycle and decrements the counter. When the counter reaches 0 it loads Q/R and moves to DONE.
  - DONE: done=1 for one cycle, then returns to IDLE unconditionally.
- Restoring step:
  - rem' = {rem[WIDTH-1:0], dividend MSB}, WIDTH+1 bits.
  - trial = rem' − {1'b0, divisor}, WIDTH+1 bits.
  - If trial MSB = 0: rem ← trial, shift quotient bit 1 into the dividend register LSB.
  - Otherwise: rem ← rem', shift in 0.
  - The dividend register shifts left each step and becomes the quotient.
- Results:
  - Q = final quotient register.
  - R = rem[WIDTH-1:0]; rem[WIDTH] is always 0 at completion.
- start while busy: ignored, no queuing. This includes start asserted during DONE.
- A/B changes after accept: no effect.
- Divisor 0 without zero detection: the algorithm naturally yields Q = all ones and R = A.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, busy=0, done=0, Q=0, R=0, dbz=0, all internal registers 0.
- Reset mid-operation aborts immediately. Outputs return to reset values; no done is issued.
- Latency, with start high in cycle c (accepted at edge 0):
  - busy=1 from cycle c+1.
  - CALC occupies cycles c+1 … c+WIDTH.
  - done=1 and Q/R updated in cycle c+WIDTH+1.
  - busy=0 and a new start is accepted in cycle c+WIDTH+2.
  - For WIDTH=4: done appears 5 cycles after start.
- Throughput: one division per WIDTH+2 cycles.
- done is never high for two consecutive cycles.

## Configuration
- BIN_DIV_ZERO_DET_EN defined:
  - On accept with B=0, skip CALC and go straight to DONE.
  - Q = all ones, R = A, dbz=1; done in cycle c+1.
  - dbz clears on the next accepted start.
- BIN_DIV_ZERO_DET_EN undefined:
  - No special case; B=0 takes the full WIDTH+1 latency and gives Q = all ones, R = A.
  - dbz tied to 0.

## Structure
- Package bin_div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Default WIDTH constant.
  - Counter width function: clog2(WIDTH+1).
- Sub-module bin_div_step: purely combinational single restoring step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
- The top level owns the FSM, counter and registers.

## Test plan
All scenarios use WIDTH=4.
- 13 / 4 → Q=3, R=1; done in cycle c+5; busy high cycles c+1…c+5.
- 15 / 1 → Q=15, R=0; 3 / 7 → Q=0, R=3; 0 / 5 → Q=0, R=0.
- 9 / 0:
  - With BIN_DIV_ZERO_DET_EN → Q=15, R=9, dbz=1, done in cycle c+1.
  - Without → Q=15, R=9, dbz=0, done in cycle c+5.
- start 13/4, then start 6/3 pulsed in cycles c+2 and c+5 → only 13/4 result produced; 6/3 accepted only when busy=0.
- Reset asserted asynchronously in cycle c+3 of 14/3 → busy, done, Q, R immediately 0; no done pulse; a subsequent 14/3 gives Q=4, R=2.
- Exhaustive sweep over all 256 A/B pairs, back-to-back starts → Q·B+R=A and R<B for every B≠0.

Source files
------------

// File: rtl/bin_div_pkg.sv
// ----------------------------------------------------------------------------
// bin_div_pkg
// Shared types and constants for the sequential restoring divider.
//   state_t    : FSM encoding {IDLE, CALC, DONE}
//   DEF_WIDTH  : default operand width
//   cnt_width  : width of a step counter that must hold the value WIDTH
// ----------------------------------------------------------------------------
package bin_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 4;

   // Bits needed to count down from width to 0 inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bin_div_step.sv
// ----------------------------------------------------------------------------
// bin_div_step
// One combinational restoring-division step.
// Ports:
//   rem      in  WIDTH  current partial remainder
//   dvd_msb  in  1      dividend bit being brought down this step
//   divisor  in  WIDTH  divisor
//   rem_next out WIDTH  partial remainder after the step
//   q_bit    out 1      quotient bit produced by the step
// The remainder after a step is always below the divisor, so it fits in WIDTH
// bits. If the shifted value reaches 2^WIDTH, it also exceeds any divisor,
// so the trial subtraction succeeds and clears that top bit. A restored value
// only occurs when the shifted value is below the divisor, so its top bit is
// zero too.
// ----------------------------------------------------------------------------
module bin_div_step
   import bin_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] rem_shift_s;
   logic [WIDTH:0] trial_s;

   // Shift in the next dividend bit, trial-subtract, and restore when negative.
   always_comb begin
      rem_shift_s = {rem, dvd_msb};
      trial_s     = rem_shift_s - {1'b0, divisor};
      q_bit       = ~trial_s[WIDTH];
      if (trial_s[WIDTH] == 1'b0) begin
         rem_next = trial_s[WIDTH-1:0];
      end else begin
         rem_next = rem_shift_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/bin_div_4bits_seq.sv
// ----------------------------------------------------------------------------
// bin_div_4bits_seq
// Sequential restoring unsigned divider. It performs one shift-subtract step
// per clock, MSB first.
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous active-low reset; release is expected
//                     synchronous to clk
//   start  in  1      request, sampled only while idle
//   A      in  WIDTH  dividend, latched on accept
//   B      in  WIDTH  divisor, latched on accept
//   busy   out 1      high whenever the unit is not idle
//   done   out 1      one-cycle strobe; Q/R (and dbz) valid
//   Q      out WIDTH  quotient, held until the next completion
//   R      out WIDTH  remainder, held until the next completion
//   dbz    out 1      divide-by-zero flag
// Build option:
//   BIN_DIV_ZERO_DET_EN - when defined, B = 0 bypasses the CALC steps and
//   completes one cycle after accept with dbz = 1. Otherwise dbz is tied low,
//   and B = 0 runs the normal algorithm, giving Q = all ones and R = A.
// ----------------------------------------------------------------------------
module bin_div_4bits_seq
   import bin_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             dbz
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

   state_t           state_r;
   state_t           state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] r_r;
   logic             busy_r;
   logic             done_r;

   logic             accept_s;
   logic             last_step_s;
   logic             zero_div_s;
   logic             busy_s;
   logic             done_s;
   logic [WIDTH-1:0] rem_nx_s;
   logic             qbit_s;

`ifdef BIN_DIV_ZERO_DET_EN
   assign zero_div_s = (B == {WIDTH{1'b0}});
`else
   assign zero_div_s = 1'b0;
`endif

   bin_div_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .rem      (rem_r),
      .dvd_msb  (dvd_r[WIDTH-1]),
      .divisor  (dvs_r),
      .rem_next (rem_nx_s),
      .q_bit    (qbit_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic. start is ignored outside IDLE, including in DONE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (zero_div_s) begin
                  state_s = DONE;
               end else begin
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == CNT_ONE) begin
               state_s = DONE;
            end else begin
               state_s = CALC;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // FSM output decode. busy/done are decoded from the next state and then
   // registered, so they line up with the state they describe.
   always_comb begin
      busy_s      = 1'b0;
      done_s      = 1'b0;
      accept_s    = 1'b0;
      last_step_s = 1'b0;
      if (state_s != IDLE) begin
         busy_s = 1'b1;
      end else begin
         busy_s = 1'b0;
      end
      if (state_s == DONE) begin
         done_s = 1'b1;
      end else begin
         done_s = 1'b0;
      end
      if ((state_r == IDLE) && start) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if ((state_r == CALC) && (cnt_r == CNT_ONE)) begin
         last_step_s = 1'b1;
      end else begin
         last_step_s = 1'b0;
      end
   end

   // Registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
      end
   end

   // Operand latch and iteration datapath. The dividend register shifts left
   // each step, and the quotient bits fill it from the LSB.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dvd_r <= {WIDTH{1'b0}};
         dvs_r <= {WIDTH{1'b0}};
         rem_r <= {WIDTH{1'b0}};
         cnt_r <= CNT_ZERO;
      end else if (accept_s) begin
         dvd_r <= A;
         dvs_r <= B;
         rem_r <= {WIDTH{1'b0}};
         cnt_r <= CNT_INIT;
      end else if (state_r == CALC) begin
         dvd_r <= {dvd_r[WIDTH-2:0], qbit_s};
         rem_r <= rem_nx_s;
         cnt_r <= cnt_r - CNT_ONE;
      end else begin
         dvd_r <= dvd_r;
         dvs_r <= dvs_r;
         rem_r <= rem_r;
         cnt_r <= cnt_r;
      end
   end

   // Result registers. They are loaded only at completion and held otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r <= {WIDTH{1'b0}};
         r_r <= {WIDTH{1'b0}};
      end else if (accept_s && zero_div_s) begin
         q_r <= {WIDTH{1'b1}};
         r_r <= A;
      end else if (last_step_s) begin
         q_r <= {dvd_r[WIDTH-2:0], qbit_s};
         r_r <= rem_nx_s;
      end else begin
         q_r <= q_r;
         r_r <= r_r;
      end
   end

`ifdef BIN_DIV_ZERO_DET_EN
   logic dbz_r;

   // Divide-by-zero flag. It is set or cleared on every accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dbz_r <= 1'b0;
      end else if (accept_s) begin
         dbz_r <= zero_div_s;
      end else begin
         dbz_r <= dbz_r;
      end
   end

   assign dbz = dbz_r;
`else
   assign dbz = 1'b0;
`endif

   assign busy = busy_r;
   assign done = done_r;
   assign Q    = q_r;
   assign R    = r_r;

endmodule

// File: tb/tb_bin_div_4bits_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_div_4bits_seq
// Directed testbench for the 4-bit sequential restoring divider. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_bin_div_4bits_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       busy;
   logic       done;
   logic [3:0] Q;
   logic [3:0] R;
   logic       dbz;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef BIN_DIV_ZERO_DET_EN
   localparam int  ZLAT = 1;
   localparam logic ZDBZ = 1'b1;
`else
   localparam int  ZLAT = 5;
   localparam logic ZDBZ = 1'b0;
`endif

   bin_div_4bits_seq #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dbz   (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle, scramble the operands after accept, and return
   // in the cycle where done is seen. lat is the number of cycles from start
   // to done, or 0 if done did not appear within the bound.
   task automatic run_div(input logic [3:0] a, input logic [3:0] b, output int lat);
      start = 1'b1;
      A     = a;
      B     = b;
      step();
      start = 1'b0;
      A     = ~a;
      B     = ~b;
      lat   = 0;
      for (int k = 1; k <= 20; k++) begin
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      A     = 4'd0;
      B     = 4'd0;
      #12;
      n_checks++;
      if ({busy, done, dbz} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags busy/done/dbz got %b required 000", {busy, done, dbz});
      end
      n_checks++;
      if ({Q, R} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_qr Q/R got %0d/%0d required 0/0", Q, R);
      end
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_basic();
      start = 1'b1;
      A     = 4'd13;
      B     = 4'd4;
      step();
      start = 1'b0;
      A     = 4'd0;
      B     = 4'd0;
      for (int k = 1; k <= 6; k++) begin
         n_checks++;
         if (busy !== (k <= 5)) begin
            n_fail++;
            $display("FAIL basic_busy cycle c+%0d got %b required %b", k, busy, (k <= 5));
         end
         n_checks++;
         if (done !== (k == 5)) begin
            n_fail++;
            $display("FAIL basic_done cycle c+%0d got %b required %b", k, done, (k == 5));
         end
         if (k == 5) begin
            n_checks++;
            if (Q !== 4'd3 || R !== 4'd1) begin
               n_fail++;
               $display("FAIL basic_13_4 got Q=%0d R=%0d required Q=3 R=1", Q, R);
            end
         end
         if (k < 6) step();
      end
      step();
      step();
      n_checks++;
      if (Q !== 4'd3 || R !== 4'd1) begin
         n_fail++;
         $display("FAIL basic_hold got Q=%0d R=%0d required Q=3 R=1", Q, R);
      end
   endtask

   task automatic test_vectors();
      logic [3:0] va [5]   = '{4'd15, 4'd3, 4'd9, 4'd0, 4'd14};
      logic [3:0] vb [5]   = '{4'd1,  4'd7, 4'd0, 4'd5, 4'd3};
      logic [3:0] vq [5]   = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd4};
      logic [3:0] vr [5]   = '{4'd0,  4'd3, 4'd9, 4'd0, 4'd2};
      int         vl [5]   = '{5, 5, ZLAT, 5, 5};
      logic       vz [5]   = '{1'b0, 1'b0, ZDBZ, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         run_div(va[i], vb[i], lat);
         n_checks++;
         if (lat !== vl[i]) begin
            n_fail++;
            $display("FAIL vec_latency %0d/%0d got %0d required %0d", va[i], vb[i], lat, vl[i]);
         end
         n_checks++;
         if (Q !== vq[i] || R !== vr[i] || dbz !== vz[i]) begin
            n_fail++;
            $display("FAIL vec_result %0d/%0d got Q=%0d R=%0d dbz=%b required Q=%0d R=%0d dbz=%b",
                     va[i], vb[i], Q, R, dbz, vq[i], vr[i], vz[i]);
         end
         step();
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_idle %0d/%0d got busy=%b done=%b required 0 0", va[i], vb[i], busy, done);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      start = 1'b1;
      A     = 4'd13;
      B     = 4'd4;
      step();
      for (int k = 1; k <= 11; k++) begin
         start = (k == 2 || k == 5);
         A     = 4'd6;
         B     = 4'd3;
         if (k == 5) begin
            n_checks++;
            if (done !== 1'b1 || Q !== 4'd3 || R !== 4'd1) begin
               n_fail++;
               $display("FAIL ignore_first got done=%b Q=%0d R=%0d required 1 3 1", done, Q, R);
            end
         end else begin
            n_checks++;
            if (done !== 1'b0) begin
               n_fail++;
               $display("FAIL ignore_done cycle c+%0d got %b required 0", k, done);
            end
         end
         if (k >= 6) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL ignore_busy cycle c+%0d got %b required 0", k, busy);
            end
         end
         step();
         start = 1'b0;
      end
      run_div(4'd6, 4'd3, lat);
      n_checks++;
      if (lat !== 5 || Q !== 4'd2 || R !== 4'd0) begin
         n_fail++;
         $display("FAIL ignore_second got lat=%0d Q=%0d R=%0d required 5 2 0", lat, Q, R);
      end
      step();
   endtask

   task automatic test_async_reset();
      int lat;
      start = 1'b1;
      A     = 4'd14;
      B     = 4'd3;
      step();
      start = 1'b0;
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || Q !== 4'd0 || R !== 4'd0) begin
         n_fail++;
         $display("FAIL abort_outputs got busy=%b done=%b Q=%0d R=%0d required 0 0 0 0", busy, done, Q, R);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet cycle %0d got busy=%b done=%b required 0 0", k, busy, done);
         end
      end
      run_div(4'd14, 4'd3, lat);
      n_checks++;
      if (lat !== 5 || Q !== 4'd4 || R !== 4'd2) begin
         n_fail++;
         $display("FAIL abort_rerun got lat=%0d Q=%0d R=%0d required 5 4 2", lat, Q, R);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int lat;
      int qi;
      int ri;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_div(a[3:0], b[3:0], lat);
            qi = int'(Q);
            ri = int'(R);
            n_checks++;
            if (lat !== ((b == 0) ? ZLAT : 5)) begin
               n_fail++;
               $display("FAIL sweep_latency %0d/%0d got %0d required %0d", a, b, lat, (b == 0) ? ZLAT : 5);
            end
            n_checks++;
            if (b != 0) begin
               if ((qi * b + ri) != a || ri >= b) begin
                  n_fail++;
                  $display("FAIL sweep_identity %0d/%0d got Q=%0d R=%0d required Q*B+R=A and R<B", a, b, qi, ri);
               end
            end else begin
               if (qi != 15 || ri != a) begin
                  n_fail++;
                  $display("FAIL sweep_zero %0d/0 got Q=%0d R=%0d required Q=15 R=%0d", a, qi, ri, a);
               end
            end
            step();
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_busy_ignore();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
